mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles to wait for i_mem_ack before aborting an access (range 1..255).
REQ-002 SHALL have the following ports:
- i_clk  input  1  clock, all state updates on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_if_req  input  1  fetch requester wants a read
- i_if_addr  input  32  fetch address
- o_if_gnt  output  1  fetch request accepted this cycle
- o_if_rvalid  output  1  fetch read data valid, one-cycle pulse
- o_if_rdata  output  32  fetch read data
- i_ls_req  input  1  load/store requester wants an access
- i_ls_we  input  1  1 = store, 0 = load
- i_ls_addr  input  32  load/store address
- i_ls_wdata  input  32  store data
- i_ls_be  input  4  store byte enables
- o_ls_gnt  output  1  load/store request accepted this cycle
- o_ls_done  output  1  load/store access completed, one-cycle pulse
- o_ls_rdata  output  32  load read data
- o_mem_req  output  1  memory access in progress
- o_mem_we  output  1  memory write enable
- o_mem_addr  output  32  memory address
- o_mem_wdata  output  32  memory write data
- o_mem_be  output  4  memory byte enables
- i_mem_ack  input  1  memory has completed the current access
- i_mem_rdata  input  32  memory read data, valid when i_mem_ack = 1
- o_err  output  1  timeout abort, one-cycle pulse
- o_busy  output  1  state is not IDLE

Function
REQ-003 SHALL implement a state machine with three states: IDLE, IF_ACC and LS_ACC.
REQ-004 In IDLE, o_if_gnt and o_ls_gnt SHALL be combinational from the requests, and at most one of them SHALL be 1 in any cycle.
REQ-005 SHALL grant the only requester when exactly one request is high.
REQ-006 SHALL resolve a tie by granting the requester that was not served last (round-robin); the last-served flag updates on every grant.
REQ-007 On a grant, the address, and for the load/store requester also we, wdata and be, SHALL be captured at that clock edge, and the state SHALL move to IF_ACC or LS_ACC.
REQ-008 A fetch grant SHALL drive o_mem_we = 0 and o_mem_be = 4'b1111.
REQ-009 In IF_ACC and LS_ACC, o_mem_req SHALL be 1 and the o_mem_* outputs SHALL hold the captured values, stable until exit.
REQ-010 No grant SHALL be issued in IF_ACC or LS_ACC, whatever the request inputs are.
REQ-011 When i_mem_ack = 1 in an ACC state, i_mem_rdata SHALL be registered into o_if_rdata or o_ls_rdata, and the state SHALL return to IDLE.
REQ-012 In the cycle after that ack, exactly one completion pulse SHALL be asserted: o_if_rvalid = 1 for a fetch, o_ls_done = 1 for a load or a store.
REQ-013 o_ls_rdata SHALL be left unchanged after a store.
REQ-014 A new grant SHALL be possible in the same cycle as the completion pulse, giving back-to-back accesses with one IDLE cycle between them.
REQ-015 Minimum latency SHALL be: request sampled in cycle N, o_mem_req in cycle N+1, ack in N+1, completion pulse in N+2.
REQ-016 o_if_rdata and o_ls_rdata SHALL hold their values until the next completion for the same requester.
REQ-017 i_mem_ack SHALL be ignored in IDLE.
REQ-018 An 8-bit wait counter SHALL clear on entry to an ACC state and increment each ACC cycle without an ack.
REQ-019 When the counter equals TIMEOUT_CYC and no ack is present, the block SHALL go to IDLE, pulse o_err for one cycle, and assert no completion pulse.
REQ-020 An ack in the same cycle as the timeout condition SHALL take priority: normal completion, no o_err.
REQ-021 o_busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-022 i_rst = 1 SHALL immediately force:
- state = IDLE and the wait counter = 0
- all outputs = 0, including the rdata registers
- the last-served flag = LS, so the fetch requester wins the first tie.
REQ-023 Reset during an ACC state SHALL abandon the access with no completion pulse and no o_err; a late i_mem_ack after reset is ignored per REQ-017.

Verification
REQ-024 Single fetch: i_if_req=1 with addr 0x100 in cycle 0; ack with rdata 0xDEADBEEF in cycle 1 -> o_if_gnt in cycle 0, o_mem_req/addr 0x100/we 0 in cycle 1, o_if_rvalid=1 with rdata 0xDEADBEEF in cycle 2.
REQ-025 Tie after reset: both requests held high -> grant order IF, LS, IF, LS; o_ls_done and o_if_rvalid alternate; never both gnt bits high.
REQ-026 Store: we=1, addr 0x200, wdata 0x12345678, be 4'b0011, ack after 3 wait cycles -> o_mem_* hold those values for 4 cycles, then o_ls_done pulse, o_ls_rdata unchanged.
REQ-027 Timeout with TIMEOUT_CYC=4 and no ack -> o_mem_req high for 5 cycles, o_err pulses once, o_busy drops, no completion pulse; ack in the timeout cycle instead -> completion, no o_err.
REQ-028 Reset mid-access: assert i_rst while in LS_ACC -> all outputs 0 at once; an ack arriving after reset release gives no pulse; the next tie grants IF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fetch and load/store share one memory
// port, round-robin on ties, with a wait-cycle timeout abort.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_be,
    output logic        o_ls_gnt,
    output logic        o_ls_done,
    output logic [31:0] o_ls_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        last_ls_q, last_ls_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_done_q, ls_done_d;
    logic        err_q, err_d;

    logic        if_gnt;
    logic        ls_gnt;
    logic        in_acc;
    logic        timeout;

    assign in_acc  = (state_q != IDLE);
    assign timeout = (wait_q == 8'(TIMEOUT_CYC));

    // State register and all datapath flops, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            last_ls_q   <= 1'b1;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
            if_rvalid_q <= 1'b0;
            ls_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            last_ls_q   <= last_ls_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_done_q   <= ls_done_d;
            err_q       <= err_d;
        end
    end

    // Next-state: leave IDLE on a grant, return on ack or timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    state_d = IF_ACC;
                end else if (ls_gnt) begin
                    state_d = LS_ACC;
                end
            end
            IF_ACC, LS_ACC: begin
                if (i_mem_ack || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: grants only in IDLE, masked while reset is held
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!i_rst && state_q == IDLE) begin
            if (i_if_req && i_ls_req) begin
                if_gnt = last_ls_q;
                ls_gnt = !last_ls_q;
            end else begin
                if_gnt = i_if_req;
                ls_gnt = i_ls_req;
            end
        end
    end

    // Datapath: capture on grant, count waits, register read data and pulses
    always_comb begin
        wait_d      = wait_q;
        last_ls_d   = last_ls_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_done_d   = 1'b0;
        err_d       = 1'b0;
        if (!in_acc) begin
            if (if_gnt) begin
                addr_d    = i_if_addr;
                we_d      = 1'b0;
                wdata_d   = 32'd0;
                be_d      = 4'b1111;
                wait_d    = 8'd0;
                last_ls_d = 1'b0;
            end else if (ls_gnt) begin
                addr_d    = i_ls_addr;
                we_d      = i_ls_we;
                wdata_d   = i_ls_wdata;
                be_d      = i_ls_be;
                wait_d    = 8'd0;
                last_ls_d = 1'b1;
            end
        end else if (i_mem_ack) begin
            if (state_q == IF_ACC) begin
                if_rdata_d  = i_mem_rdata;
                if_rvalid_d = 1'b1;
            end else begin
                if (!we_q) begin
                    ls_rdata_d = i_mem_rdata;
                end
                ls_done_d = 1'b1;
            end
        end else if (timeout) begin
            err_d = 1'b1;
        end else begin
            wait_d = wait_q + 8'd1;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_ls_gnt    = ls_gnt;
    assign o_if_rvalid = if_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_done   = ls_done_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_req   = in_acc;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;
    assign o_err       = err_q;
    assign o_busy      = in_acc;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks with a
// scoreboard of expected completions.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        ls_gnt, ls_done;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err, busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_ls;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    mem_port_arbiter #(.TIMEOUT_CYC(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_be(ls_be),
        .o_ls_gnt(ls_gnt), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_err(err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_req = 1'b1;
        ls_req = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({if_gnt, ls_gnt, mem_req, busy, err, if_rvalid, ls_done} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {if_gnt, ls_gnt, mem_req, busy, err, if_rvalid, ls_done});
        end
        checks++;
        if ({if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be, mem_we} !== '0) begin
            failures++;
            $display("FAIL reset_data if_rdata=%h ls_rdata=%h addr=%h",
                     if_rdata, ls_rdata, mem_addr);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1;
        if_addr = 32'h100;
        #1;
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
            failures++;
            $display("FAIL fetch_gnt got=%b%b want=10", if_gnt, ls_gnt);
        end
        sb.push_back('{is_ls: 1'b0, data: 32'hDEADBEEF});
        step();
        if_req = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0
            || mem_be !== 4'hF || busy !== 1'b1) begin
            failures++;
            $display("FAIL fetch_mem req=%b addr=%h we=%b be=%h want 1/100/0/f",
                     mem_req, mem_addr, mem_we, mem_be);
        end
        step();
        mem_ack = 1'b0;
        e = sb.pop_front();
        checks++;
        if (if_rvalid !== 1'b1 || ls_done !== 1'b0 || if_rdata !== e.data) begin
            failures++;
            $display("FAIL fetch_done rvalid=%b done=%b rdata=%h want 1/0/%h",
                     if_rvalid, ls_done, if_rdata, e.data);
        end
        step();
        checks++;
        if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse rvalid=%b busy=%b want 0/0", if_rvalid, busy);
        end
    endtask

    task automatic test_tie();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        if_req = 1'b1;
        ls_req = 1'b1;
        ls_we = 1'b0;
        if_addr = 32'h400;
        ls_addr = 32'h800;
        for (int k = 0; k < 4; k++) begin
            bit exp_ls;
            logic [31:0] d;
            exp_ls = (k % 2) == 1;
            d = 32'hA000_0000 + 32'(k);
            #1;
            checks++;
            if (if_gnt !== !exp_ls || ls_gnt !== exp_ls) begin
                failures++;
                $display("FAIL tie_gnt k=%0d got=%b%b want_ls=%b", k, if_gnt, ls_gnt, exp_ls);
            end
            sb.push_back('{is_ls: exp_ls, data: d});
            step();
            mem_ack = 1'b1;
            mem_rdata = d;
            checks++;
            if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL tie_acc_gnt k=%0d gnt=%b%b req=%b", k, if_gnt, ls_gnt, mem_req);
            end
            step();
            mem_ack = 1'b0;
            e = sb.pop_front();
            checks++;
            if (ls_done !== e.is_ls || if_rvalid !== !e.is_ls
                || (e.is_ls ? ls_rdata : if_rdata) !== e.data) begin
                failures++;
                $display("FAIL tie_done k=%0d rvalid=%b done=%b if=%h ls=%h want %h",
                         k, if_rvalid, ls_done, if_rdata, ls_rdata, e.data);
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_addr = 32'h200;
        ls_wdata = 32'h12345678;
        ls_be = 4'b0011;
        #1;
        checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            failures++;
            $display("FAIL store_gnt got=%b%b want=01", if_gnt, ls_gnt);
        end
        sb.push_back('{is_ls: 1'b1, data: 32'hA000_0003});
        step();
        ls_req = 1'b0;
        ls_addr = 32'hFFFF_FFFF;
        ls_wdata = 32'h0;
        ls_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200
                || mem_wdata !== 32'h12345678 || mem_be !== 4'b0011 || ls_done !== 1'b0) begin
                failures++;
                $display("FAIL store_hold i=%0d req=%b we=%b addr=%h wd=%h be=%b",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
            end
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
            step();
        end
        mem_ack = 1'b0;
        e = sb.pop_front();
        checks++;
        if (ls_done !== 1'b1 || if_rvalid !== 1'b0 || ls_rdata !== e.data) begin
            failures++;
            $display("FAIL store_done done=%b rvalid=%b ls_rdata=%h want 1/0/%h",
                     ls_done, if_rvalid, ls_rdata, e.data);
        end
        ls_we = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        if_req = 1'b1;
        if_addr = 32'h500;
        #1;
        step();
        if_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!mem_req) break;
            cnt++;
            checks++;
            if (if_rvalid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait i=%0d rvalid=%b err=%b", i, if_rvalid, err);
            end
            step();
        end
        checks++;
        if (cnt !== 5) begin
            failures++;
            $display("FAIL timeout_len got=%0d want=5", cnt);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || if_rvalid !== 1'b0 || ls_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err err=%b busy=%b rvalid=%b done=%b want 1/0/0/0",
                     err, busy, if_rvalid, ls_done);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse err=%b want=0", err);
        end
    endtask

    task automatic test_ack_at_timeout();
        if_req = 1'b1;
        if_addr = 32'h600;
        #1;
        sb.push_back('{is_ls: 1'b0, data: 32'h55AA55AA});
        step();
        if_req = 1'b0;
        repeat (4) step();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL ack_to_req req=%b want=1", mem_req);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h55AA55AA;
        step();
        mem_ack = 1'b0;
        e = sb.pop_front();
        checks++;
        if (err !== 1'b0 || if_rvalid !== 1'b1 || if_rdata !== e.data) begin
            failures++;
            $display("FAIL ack_to_done err=%b rvalid=%b rdata=%h want 0/1/%h",
                     err, if_rvalid, if_rdata, e.data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ls_req = 1'b1;
        ls_we = 1'b0;
        ls_addr = 32'h300;
        #1;
        checks++;
        if (ls_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_gnt ls_gnt=%b want=1", ls_gnt);
        end
        step();
        ls_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL rmid_acc busy=%b addr=%h want 1/300", busy, mem_addr);
        end
        if_req = 1'b1;
        ls_req = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({if_gnt, ls_gnt, mem_req, busy, err, if_rvalid, ls_done, mem_we} !== 8'd0
            || {if_rdata, ls_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin
            failures++;
            $display("FAIL rmid_clear ctrl=%b if=%h ls=%h addr=%h",
                     {if_gnt, ls_gnt, mem_req, busy, err, if_rvalid, ls_done, mem_we},
                     if_rdata, ls_rdata, mem_addr);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        checks++;
        if (if_rvalid !== 1'b0 || ls_done !== 1'b0 || err !== 1'b0 || busy !== 1'b0
            || ls_rdata !== 32'd0) begin
            failures++;
            $display("FAIL rmid_late_ack rvalid=%b done=%b err=%b busy=%b ls=%h",
                     if_rvalid, ls_done, err, busy, ls_rdata);
        end
        if_req = 1'b1;
        ls_req = 1'b1;
        #1;
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rmid_tie got=%b%b want=10", if_gnt, ls_gnt);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_single_fetch();
        test_tie();
        test_store();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sb_empty left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
